serial_adder: RTL and testbench

- Parametrised multi-bit adder that reuses one BITS-wide adder slice over several clock cycles, processing operands LSB-first.
- Successor to the single-bit full adder, with a start/busy/done handshake, a registered carry chain and signed-overflow detection.
- Used where area matters more than latency; it sits between a controller that issues operands and a consumer that samples the result on done.

---
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Multi-cycle adder that reuses one BITS-wide slice, LSB-first, with a start/busy/done
// handshake. Results appear on sum/cout/overflow only when an operation completes.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int BITS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   psum_r;

    logic [BITS:0]      slice_s;
    logic               msb_cin_s;
    logic [WIDTH-1:0]   psum_next_s;
    logic               last_s;

    function automatic logic [BITS:0] slice_add(
        input logic [BITS-1:0] x,
        input logic [BITS-1:0] y,
        input logic            c
    );
        return {1'b0, x} + {1'b0, y} + {{BITS{1'b0}}, c};
    endfunction

    // Slice datapath; the carry into the slice MSB is recovered as x ^ y ^ sum_bit.
    always_comb begin
        slice_s     = slice_add(a_r[BITS-1:0], b_r[BITS-1:0], carry_r);
        msb_cin_s   = a_r[BITS-1] ^ b_r[BITS-1] ^ slice_s[BITS-1];
        psum_next_s = (psum_r >> BITS) | (WIDTH'(slice_s[BITS-1:0]) << (WIDTH - BITS));
        last_s      = (cnt_r == CNT_W'(N - 1));
    end

    // Control FSM, operand/carry shift registers and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            psum_r   <= {WIDTH{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= {WIDTH{1'b0}};
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        cnt_r   <= {CNT_W{1'b0}};
                        psum_r  <= {WIDTH{1'b0}};
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> BITS;
                    b_r     <= b_r >> BITS;
                    carry_r <= slice_s[BITS];
                    cnt_r   <= cnt_r + 1'b1;
                    psum_r  <= psum_next_s;
                    if (last_s) begin
                        sum      <= psum_next_s;
                        cout     <= slice_s[BITS];
                        overflow <= msb_cin_s ^ slice_s[BITS];
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_r  <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: four parameterisations share clock and reset,
// expected results are queued at issue time and popped on each done pulse.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // WIDTH=8, BITS=1
    logic       start81 = 1'b0, cin81 = 1'b0;
    logic [7:0] a81 = 8'h00, b81 = 8'h00;
    logic       busy81, done81, cout81, ovf81;
    logic [7:0] sum81;
    // WIDTH=8, BITS=4
    logic       start84 = 1'b0, cin84 = 1'b0;
    logic [7:0] a84 = 8'h00, b84 = 8'h00;
    logic       busy84, done84, cout84, ovf84;
    logic [7:0] sum84;
    // WIDTH=3, BITS=1 and BITS=3 share their stimulus
    logic       start3 = 1'b0, cin3 = 1'b0;
    logic [2:0] a3 = 3'd0, b3 = 3'd0;
    logic       busy31, done31, cout31, ovf31;
    logic [2:0] sum31;
    logic       busy33, done33, cout33, ovf33;
    logic [2:0] sum33;

    logic [9:0] q81[$];
    logic [9:0] q84[$];
    logic [4:0] q31[$];
    logic [4:0] q33[$];
    logic [9:0] last81 = 10'd0;
    int         ndone31 = 0, ndone33 = 0;

    serial_adder #(.WIDTH(8), .BITS(1)) u81 (
        .clk(clk), .rst(rst), .start(start81), .a(a81), .b(b81), .cin(cin81),
        .busy(busy81), .done(done81), .sum(sum81), .cout(cout81), .overflow(ovf81));
    serial_adder #(.WIDTH(8), .BITS(4)) u84 (
        .clk(clk), .rst(rst), .start(start84), .a(a84), .b(b84), .cin(cin84),
        .busy(busy84), .done(done84), .sum(sum84), .cout(cout84), .overflow(ovf84));
    serial_adder #(.WIDTH(3), .BITS(1)) u31 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy31), .done(done31), .sum(sum31), .cout(cout31), .overflow(ovf31));
    serial_adder #(.WIDTH(3), .BITS(3)) u33 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy33), .done(done33), .sum(sum33), .cout(cout33), .overflow(ovf33));

    // Reference: {overflow, cout, sum} from a wide unsigned sum and a signed range test
    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] full;
        int         s;
        full = x + y + c;
        s    = int'($signed(x)) + int'($signed(y)) + int'(c);
        return {(s > 127 || s < -128), full};
    endfunction

    function automatic logic [4:0] model3(input logic [2:0] x, input logic [2:0] y, input logic c);
        logic [3:0] full;
        int         s;
        full = x + y + c;
        s    = int'($signed(x)) + int'($signed(y)) + int'(c);
        return {(s > 3 || s < -4), full};
    endfunction

    // Scoreboard monitors: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (done81) begin
            vectors++;
            if (q81.size() == 0) begin
                miscompares++;
                $display("FAIL sb81_unexpected_done got=%h expected no done", {ovf81, cout81, sum81});
            end else begin
                last81 = q81.pop_front();
                if ({ovf81, cout81, sum81} !== last81) begin
                    miscompares++;
                    $display("FAIL sb81_result got=%h expected=%h", {ovf81, cout81, sum81}, last81);
                end
            end
        end
        if (done84) begin
            vectors++;
            if (q84.size() == 0) begin
                miscompares++;
                $display("FAIL sb84_unexpected_done got=%h", {ovf84, cout84, sum84});
            end else if ({ovf84, cout84, sum84} !== q84[0]) begin
                miscompares++;
                $display("FAIL sb84_result got=%h expected=%h", {ovf84, cout84, sum84}, q84.pop_front());
            end else begin
                void'(q84.pop_front());
            end
        end
        if (done31) begin
            ndone31++;
            vectors++;
            if (q31.size() == 0) begin
                miscompares++;
                $display("FAIL sb31_unexpected_done got=%h", {ovf31, cout31, sum31});
            end else if ({ovf31, cout31, sum31} !== q31[0]) begin
                miscompares++;
                $display("FAIL sb31_result got=%h expected=%h", {ovf31, cout31, sum31}, q31.pop_front());
            end else begin
                void'(q31.pop_front());
            end
        end
        if (done33) begin
            ndone33++;
            vectors++;
            if (q33.size() == 0) begin
                miscompares++;
                $display("FAIL sb33_unexpected_done got=%h", {ovf33, cout33, sum33});
            end else if ({ovf33, cout33, sum33} !== q33[0]) begin
                miscompares++;
                $display("FAIL sb33_result got=%h expected=%h", {ovf33, cout33, sum33}, q33.pop_front());
            end else begin
                void'(q33.pop_front());
            end
        end
    end

    // Issue one operation on the 8/1 instance and wait (bounded) for its done pulse
    task automatic issue_81(input logic [7:0] x, input logic [7:0] y, input logic c);
        bit got = 1'b0;
        @(posedge clk); #1;
        a81 = x; b81 = y; cin81 = c; start81 = 1'b1;
        q81.push_back(model8(x, y, c));
        @(posedge clk); #1;
        start81 = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done81) got = 1'b1;
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL issue81_timeout a=%h b=%h cin=%b got no done within 20 cycles", x, y, c);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy81, done81, ovf81, cout81, sum81} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset81 got=%h expected=000", {busy81, done81, ovf81, cout81, sum81});
        end
        vectors++;
        if ({busy84, done84, ovf84, cout84, sum84, busy31, done31, sum31, busy33, done33, sum33} !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_others got=%h expected=0",
                     {busy84, done84, ovf84, cout84, sum84, busy31, done31, sum31, busy33, done33, sum33});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy81, done81, ovf81, cout81, sum81} !== 12'h000) begin
            miscompares++;
            $display("FAIL idle_after_reset got=%h expected=000", {busy81, done81, ovf81, cout81, sum81});
        end
    endtask

    // 0x5A+0x3C: busy for 8 cycles, done on the 9th, previous result held meanwhile
    task automatic test_basic();
        logic [9:0] held;
        held = last81;
        @(posedge clk); #1;
        a81 = 8'h5A; b81 = 8'h3C; cin81 = 1'b0; start81 = 1'b1;
        q81.push_back(model8(8'h5A, 8'h3C, 1'b0));
        @(posedge clk); #1;
        start81 = 1'b0;
        a81 = 8'hFF; b81 = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({busy81, done81} !== {(i < 8), (i == 8)}) begin
                miscompares++;
                $display("FAIL basic_handshake cycle=%0d got busy/done=%b%b expected=%b%b",
                         i, busy81, done81, (i < 8), (i == 8));
            end
            if (i < 8) begin
                vectors++;
                if ({ovf81, cout81, sum81} !== held) begin
                    miscompares++;
                    $display("FAIL basic_hold cycle=%0d got=%h expected=%h", i, {ovf81, cout81, sum81}, held);
                end
            end
        end
        vectors++;
        if ({ovf81, cout81, sum81} !== 10'h296) begin
            miscompares++;
            $display("FAIL basic_result_kept got=%h expected=296", {ovf81, cout81, sum81});
        end
    endtask

    task automatic test_corners();
        issue_81(8'hFF, 8'h01, 1'b0);
        issue_81(8'hFF, 8'h00, 1'b1);
        issue_81(8'h80, 8'h80, 1'b0);
        issue_81(8'h7F, 8'h80, 1'b1);
    endtask

    // start held high, operands changed mid-RUN: one done every N+2 cycles
    task automatic test_start_held();
        @(posedge clk); #1;
        a81 = 8'hC3; b81 = 8'h4E; cin81 = 1'b1; start81 = 1'b1;
        q81.push_back(model8(8'hC3, 8'h4E, 1'b1));
        @(posedge clk); #1;
        a81 = 8'h11; b81 = 8'h22; cin81 = 1'b0;
        q81.push_back(model8(8'h11, 8'h22, 1'b0));
        q81.push_back(model8(8'h11, 8'h22, 1'b0));
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            vectors++;
            if (done81 !== (i == 8 || i == 18 || i == 28)) begin
                miscompares++;
                $display("FAIL held_done_spacing cycle=%0d got=%b expected=%b",
                         i, done81, (i == 8 || i == 18 || i == 28));
            end
            if (i == 28) start81 = 1'b0;
        end
        vectors++;
        if (q81.size() != 0) begin
            miscompares++;
            $display("FAIL held_pending got=%0d expected=0", q81.size());
        end
    endtask

    // Async reset during the 4th RUN cycle aborts the operation without a done pulse
    task automatic test_reset_mid_run();
        @(posedge clk); #1;
        a81 = 8'h12; b81 = 8'h34; cin81 = 1'b0; start81 = 1'b1;
        @(posedge clk); #1;
        start81 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy81, done81, ovf81, cout81, sum81} !== 12'h000) begin
            miscompares++;
            $display("FAIL midrun_async_clear got=%h expected=000", {busy81, done81, ovf81, cout81, sum81});
        end
        #1 rst = 1'b0;
        last81 = 10'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vectors++;
            if ({busy81, done81} !== 2'b00) begin
                miscompares++;
                $display("FAIL midrun_no_done cycle=%0d got busy/done=%b%b expected=00", i, busy81, done81);
            end
        end
        issue_81(8'h12, 8'h34, 1'b1);
    endtask

    // BITS=4: two RUN cycles, done on the third
    task automatic test_bits4();
        logic [7:0] ta[4] = '{8'h7F, 8'hFF, 8'h80, 8'hA5};
        logic [7:0] tb[4] = '{8'h01, 8'hFF, 8'h7F, 8'h5A};
        logic       tc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
            a84 = ta[t]; b84 = tb[t]; cin84 = tc[t]; start84 = 1'b1;
            q84.push_back(model8(ta[t], tb[t], tc[t]));
            @(posedge clk); #1;
            start84 = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                vectors++;
                if ({busy84, done84} !== {(i < 2), (i == 2)}) begin
                    miscompares++;
                    $display("FAIL bits4_handshake op=%0d cycle=%0d got=%b%b expected=%b%b",
                             t, i, busy84, done84, (i < 2), (i == 2));
                end
            end
        end
        vectors++;
        if ({ovf84, cout84, sum84} !== model8(8'hA5, 8'h5A, 1'b0) || q84.size() != 0) begin
            miscompares++;
            $display("FAIL bits4_final got=%h pending=%0d expected=%h pending=0",
                     {ovf84, cout84, sum84}, q84.size(), model8(8'hA5, 8'h5A, 1'b0));
        end
    endtask

    task automatic test_exhaustive3();
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                for (int c = 0; c < 2; c++) begin
                    @(posedge clk); #1;
                    a3 = 3'(x); b3 = 3'(y); cin3 = 1'(c); start3 = 1'b1;
                    q31.push_back(model3(3'(x), 3'(y), 1'(c)));
                    q33.push_back(model3(3'(x), 3'(y), 1'(c)));
                    @(posedge clk); #1;
                    start3 = 1'b0;
                    repeat (4) @(posedge clk);
                end
            end
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (ndone31 != 128 || ndone33 != 128 || q31.size() != 0 || q33.size() != 0) begin
            miscompares++;
            $display("FAIL exhaustive3_count got done31=%0d done33=%0d expected 128 each, pending %0d/%0d",
                     ndone31, ndone33, q31.size(), q33.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_start_held();
        test_reset_mid_run();
        test_bits4();
        test_exhaustive3();
        repeat (3) @(negedge clk);
        vectors++;
        if (q81.size() != 0) begin
            miscompares++;
            $display("FAIL final_pending81 got=%0d expected=0", q81.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation exceeded 100000 time units");
        $fatal(1);
    end

endmodule
